// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response bundle for the shared-ALU arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric.
interface alu_share_arbiter_if #(
  parameter int W = 16
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_ain;
  logic [W-1:0] req0_bin;
  logic [1:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_ain;
  logic [W-1:0] req1_bin;
  logic [1:0]   req1_op;

  logic [W-1:0] alu_ain;
  logic [W-1:0] alu_bin;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_out;
  logic [2:0]   alu_z;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_out;
  logic [2:0]   rsp_z;

  modport slave (
    input  req0_valid, req0_ain, req0_bin, req0_op,
    output req0_ready,
    input  req1_valid, req1_ain, req1_bin, req1_op,
    output req1_ready,
    output alu_ain, alu_bin, alu_op,
    input  alu_out, alu_z,
    output rsp_valid, rsp_id, rsp_out, rsp_z,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ain, req0_bin, req0_op,
    input  req0_ready,
    output req1_valid, req1_ain, req1_bin, req1_op,
    input  req1_ready,
    input  alu_ain, alu_bin, alu_op,
    output alu_out, alu_z,
    input  rsp_valid, rsp_id, rsp_out, rsp_z,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one combinational 16-bit ALU: capture winner,
// execute for one cycle, then hold result/status until the consumer takes it.
module alu_share_arbiter #(
  parameter int W         = 16,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic gnt_vld;
  logic gnt_id;
  logic accept;
  logic last;

  logic ready0;
  logic ready1;
  logic rsp_vld;

  logic signed [W-1:0] ain_p0;
  logic signed [W-1:0] bin_p0;
  logic [1:0]          op_p0;
  logic                id_p0;

  logic signed [W-1:0] out_p1;
  logic [2:0]          z_p1;

  // Winner selection; "lst" is the requester served most recently.
  function automatic logic pick_id(input logic v0, input logic v1, input logic lst);
    if (PRIO_MODE != 0) return !v0;
    if (v0 && v1)       return !lst;
    return v1 && !v0;
  endfunction

  always_comb begin
    gnt_vld = bus.req0_valid | bus.req1_valid;
    gnt_id  = pick_id(bus.req0_valid, bus.req1_valid, last);
    accept  = (state == IDLE) && gnt_vld;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready0  = 1'b0;
    ready1  = 1'b0;
    rsp_vld = 1'b0;
    case (state)
      IDLE: begin
        ready0 = gnt_vld && !gnt_id;
        ready1 = gnt_vld &&  gnt_id;
      end
      RESP:    rsp_vld = 1'b1;
      default: ;
    endcase
  end

  // p0: operand capture at the granting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ain_p0 <= '0;
      bin_p0 <= '0;
      op_p0  <= '0;
      id_p0  <= 1'b0;
      last   <= 1'b1;
    end else if (accept) begin
      ain_p0 <= gnt_id ? bus.req1_ain : bus.req0_ain;
      bin_p0 <= gnt_id ? bus.req1_bin : bus.req0_bin;
      op_p0  <= gnt_id ? bus.req1_op  : bus.req0_op;
      id_p0  <= gnt_id;
      last   <= gnt_id;
    end
  end

  // p1: ALU result and status latched at the end of the execute cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_p1 <= '0;
      z_p1   <= '0;
    end else if (state == EXEC) begin
      out_p1 <= bus.alu_out;
      z_p1   <= bus.alu_z;
    end
  end

  assign bus.alu_ain    = ain_p0;
  assign bus.alu_bin    = bin_p0;
  assign bus.alu_op     = op_p0;
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_vld;
  assign bus.rsp_id     = id_p0;
  assign bus.rsp_out    = out_p1;
  assign bus.rsp_z      = z_p1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: round-robin instance (a) and fixed-priority instance (b),
// each with a behavioural ALU on its alu_* ports.
module tb_alu_share_arbiter;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  alu_share_arbiter_if #(.W(16)) bus_a ();
  alu_share_arbiter_if #(.W(16)) bus_b ();

  alu_share_arbiter #(.W(16), .PRIO_MODE(0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  alu_share_arbiter #(.W(16), .PRIO_MODE(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
    logic [15:0] r;
    logic        ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      2'b00: begin r = a + b; ovf = (a[15] == b[15]) && (r[15] != a[15]); end
      2'b01: begin r = a - b; ovf = (a[15] != b[15]) && (r[15] != a[15]); end
      2'b10: r = a & b;
      default: r = ~b;
    endcase
    return {ovf, r[15], (r == 16'h0000), r};
  endfunction

  assign {bus_a.alu_z, bus_a.alu_out} = alu_model(bus_a.alu_ain, bus_a.alu_bin, bus_a.alu_op);
  assign {bus_b.alu_z, bus_b.alu_out} = alu_model(bus_b.alu_ain, bus_b.alu_bin, bus_b.alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus_a.req0_valid = 0; bus_a.req0_ain = 0; bus_a.req0_bin = 0; bus_a.req0_op = 0;
    bus_a.req1_valid = 0; bus_a.req1_ain = 0; bus_a.req1_bin = 0; bus_a.req1_op = 0;
    bus_a.rsp_ready  = 0;
    bus_b.req0_valid = 0; bus_b.req0_ain = 0; bus_b.req0_bin = 0; bus_b.req0_op = 0;
    bus_b.req1_valid = 0; bus_b.req1_ain = 0; bus_b.req1_bin = 0; bus_b.req1_op = 0;
    bus_b.rsp_ready  = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", bus_a.rsp_valid, 0);
    chk("rst_rsp_id",    bus_a.rsp_id,    0);
    chk("rst_rsp_out",   bus_a.rsp_out,   0);
    chk("rst_rsp_z",     bus_a.rsp_z,     0);
    chk("rst_alu_ain",   bus_a.alu_ain,   0);
    chk("rst_alu_op",    bus_a.alu_op,    0);
    chk("rst_ready0",    bus_a.req0_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single add on req0
    @(negedge clk);
    bus_a.req0_valid = 1; bus_a.req0_ain = 16'h7FFF; bus_a.req0_bin = 16'h0001; bus_a.req0_op = 2'b00;
    #1;
    chk("add_ready0",       bus_a.req0_ready, 1);
    chk("add_ready1",       bus_a.req1_ready, 0);
    chk("add_no_comb_path", bus_a.alu_ain,    0);
    @(negedge clk);
    bus_a.req0_valid = 0; bus_a.req0_ain = 16'h1111;
    #1;
    chk("add_exec_ready0", bus_a.req0_ready, 0);
    chk("add_exec_ain",    bus_a.alu_ain,    16'h7FFF);
    chk("add_exec_bin",    bus_a.alu_bin,    16'h0001);
    chk("add_exec_valid",  bus_a.rsp_valid,  0);
    @(negedge clk); #1;
    chk("add_rsp_valid", bus_a.rsp_valid, 1);
    chk("add_rsp_out",   bus_a.rsp_out,   16'h8000);
    chk("add_rsp_z",     bus_a.rsp_z,     3'b110);
    chk("add_rsp_id",    bus_a.rsp_id,    0);
    chk("add_captured",  bus_a.alu_ain,   16'h7FFF);
    @(negedge clk); #1;
    chk("add_rsp_hold", bus_a.rsp_valid, 1);
    bus_a.rsp_ready = 1;
    @(negedge clk); #1;
    chk("add_rsp_done", bus_a.rsp_valid, 0);
    bus_a.rsp_ready = 0;

    // Sub to zero on req1
    bus_a.req1_valid = 1; bus_a.req1_ain = 16'h0005; bus_a.req1_bin = 16'h0005; bus_a.req1_op = 2'b01;
    #1;
    chk("sub_ready1", bus_a.req1_ready, 1);
    chk("sub_ready0", bus_a.req0_ready, 0);
    @(negedge clk);
    bus_a.req1_valid = 0;
    @(negedge clk); #1;
    chk("sub_rsp_valid", bus_a.rsp_valid, 1);
    chk("sub_rsp_out",   bus_a.rsp_out,   16'h0000);
    chk("sub_rsp_z",     bus_a.rsp_z,     3'b001);
    chk("sub_rsp_id",    bus_a.rsp_id,    1);
    bus_a.rsp_ready = 1;
    @(negedge clk);
    bus_a.rsp_ready = 0;

    // Round-robin from reset, both requesters always valid
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus_a.req0_valid = 1; bus_a.req0_ain = 16'h0001; bus_a.req0_bin = 16'h0002; bus_a.req0_op = 2'b00;
    bus_a.req1_valid = 1; bus_a.req1_ain = 16'h0000; bus_a.req1_bin = 16'h0000; bus_a.req1_op = 2'b11;
    bus_a.rsp_ready  = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_ready0", k), bus_a.req0_ready, (k % 2 == 0));
      chk($sformatf("rr%0d_ready1", k), bus_a.req1_ready, (k % 2 == 1));
      @(negedge clk); #1;
      chk($sformatf("rr%0d_exec_ready", k), {bus_a.req0_ready, bus_a.req1_ready}, 0);
      chk($sformatf("rr%0d_exec_valid", k), bus_a.rsp_valid, 0);
      @(negedge clk); #1;
      chk($sformatf("rr%0d_rsp_valid", k), bus_a.rsp_valid, 1);
      chk($sformatf("rr%0d_rsp_id", k),    bus_a.rsp_id,    (k % 2 == 1));
      chk($sformatf("rr%0d_rsp_out", k),   bus_a.rsp_out,   (k % 2 == 0) ? 16'h0003 : 16'hFFFF);
      chk($sformatf("rr%0d_rsp_z", k),     bus_a.rsp_z,     (k % 2 == 0) ? 3'b000 : 3'b010);
      @(negedge clk);
    end
    bus_a.req0_valid = 0;
    bus_a.req1_valid = 0;
    bus_a.rsp_ready  = 0;

    // Fixed priority on instance b
    bus_b.rsp_ready  = 1;
    bus_b.req0_valid = 1; bus_b.req0_ain = 16'h0004; bus_b.req0_bin = 16'h0003; bus_b.req0_op = 2'b01;
    bus_b.req1_valid = 1; bus_b.req1_ain = 16'h0000; bus_b.req1_bin = 16'hFFFF; bus_b.req1_op = 2'b10;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("fp%0d_ready0", k), bus_b.req0_ready, 1);
      chk($sformatf("fp%0d_ready1", k), bus_b.req1_ready, 0);
      @(negedge clk); #1;
      chk($sformatf("fp%0d_exec_ready1", k), bus_b.req1_ready, 0);
      @(negedge clk); #1;
      chk($sformatf("fp%0d_rsp_id", k),  bus_b.rsp_id,  0);
      chk($sformatf("fp%0d_rsp_out", k), bus_b.rsp_out, 16'h0001);
      @(negedge clk);
    end
    bus_b.req0_valid = 0;
    #1;
    chk("fp_req1_granted", bus_b.req1_ready, 1);
    chk("fp_req0_idle",    bus_b.req0_ready, 0);
    @(negedge clk);
    bus_b.req1_valid = 0;
    @(negedge clk); #1;
    chk("fp_rsp_id",  bus_b.rsp_id,  1);
    chk("fp_rsp_out", bus_b.rsp_out, 16'h0000);
    chk("fp_rsp_z",   bus_b.rsp_z,   3'b001);
    @(negedge clk);
    bus_b.rsp_ready = 0;

    // Backpressure with req1 pending
    bus_a.req0_valid = 1; bus_a.req0_ain = 16'h0010; bus_a.req0_bin = 16'h0020; bus_a.req0_op = 2'b01;
    #1;
    chk("bp_ready0", bus_a.req0_ready, 1);
    @(negedge clk);
    bus_a.req0_valid = 0;
    bus_a.req1_valid = 1; bus_a.req1_ain = 16'h1234; bus_a.req1_bin = 16'h0001; bus_a.req1_op = 2'b00;
    #1;
    chk("bp_exec_ready1", bus_a.req1_ready, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_rsp_valid", k), bus_a.rsp_valid,  1);
      chk($sformatf("bp%0d_rsp_out", k),   bus_a.rsp_out,    16'hFFF0);
      chk($sformatf("bp%0d_rsp_z", k),     bus_a.rsp_z,      3'b010);
      chk($sformatf("bp%0d_ready1", k),    bus_a.req1_ready, 0);
      @(negedge clk);
    end
    bus_a.rsp_ready = 1;
    @(negedge clk); #1;
    chk("bp_idle_valid",   bus_a.rsp_valid,  0);
    chk("bp_req1_granted", bus_a.req1_ready, 1);
    bus_a.rsp_ready = 0;
    @(negedge clk);
    bus_a.req1_valid = 0;
    #1;
    chk("bp_exec_ain", bus_a.alu_ain, 16'h1234);
    @(negedge clk); #1;
    chk("bp_rsp1_valid", bus_a.rsp_valid, 1);
    chk("bp_rsp1_id",    bus_a.rsp_id,    1);
    chk("bp_rsp1_out",   bus_a.rsp_out,   16'h1235);
    chk("bp_rsp1_z",     bus_a.rsp_z,     3'b000);
    bus_a.rsp_ready = 1;
    @(negedge clk);
    bus_a.rsp_ready = 0;

    // Reset during EXEC
    bus_a.req0_valid = 1; bus_a.req0_ain = 16'hAAAA; bus_a.req0_bin = 16'h5555; bus_a.req0_op = 2'b00;
    @(negedge clk);
    bus_a.req0_valid = 0;
    reset_n = 1'b0;
    #1;
    chk("rexec_rsp_valid", bus_a.rsp_valid, 0);
    chk("rexec_alu_ain",   bus_a.alu_ain,   0);
    chk("rexec_alu_bin",   bus_a.alu_bin,   0);
    @(negedge clk); #1;
    chk("rexec_still_idle", bus_a.rsp_valid, 0);
    reset_n = 1'b1;
    bus_a.req0_valid = 1; bus_a.req0_ain = 16'hF0F0; bus_a.req0_bin = 16'h0FF0; bus_a.req0_op = 2'b10;
    #1;
    chk("rexec_new_ready0", bus_a.req0_ready, 1);
    @(negedge clk);
    bus_a.req0_valid = 0;
    @(negedge clk); #1;
    chk("and_rsp_valid", bus_a.rsp_valid, 1);
    chk("and_rsp_out",   bus_a.rsp_out,   16'h00F0);
    chk("and_rsp_z",     bus_a.rsp_z,     3'b000);
    chk("and_rsp_id",    bus_a.rsp_id,    0);

    // Asynchronous drop of rsp_valid while in RESP
    reset_n = 1'b0;
    #1;
    chk("async_rsp_valid", bus_a.rsp_valid, 0);
    chk("async_rsp_out",   bus_a.rsp_out,   0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
